// File: rtl/reg_file_mp_pkg.sv
// Shared constants and clear-controller state type for the multi-port register file.
package reg_file_mp_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_t;

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// Post-reset clear sequencer: sweeps registers 1..NREGS-1 to zero, then raises ready.
module reg_file_clear_ctrl
  import reg_file_mp_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);

  clr_state_t    state, state_n;
  logic [AW-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= AW'(1);
      ready <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ready <= (state_n == RUN);
    end
  end

  // Register 0 is never stored, so the sweep starts at 1 and ends on the last index.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      CLEAR: begin
        cnt_n = cnt + AW'(1);
        if (cnt == AW'(NREGS - 1)) state_n = RUN;
      end
      RUN:     state_n = RUN;
      default: state_n = CLEAR;
    endcase
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_mp.sv
// One-write, NUM_RD-read register file with x0 hardwired to zero and a sequenced clear.
// Define REG_FILE_BYPASS_EN for write-first forwarding onto the read ports.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int NUM_RD = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [XLEN-1:0]        wd,
  input  logic [NUM_RD*AW-1:0]   ra,
  output logic [NUM_RD*XLEN-1:0] rd,
  output logic                   ready
);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            wr_hit, wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  logic [XLEN-1:0] mem [1:NREGS-1];

  reg_file_clear_ctrl #(.NREGS(NREGS), .AW(AW)) u_clear (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // A write landing on the same edge as reset is dropped even if ready is still high.
  assign wr_hit = we && ready && (wa != AW'(REG_ZERO));

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wa;
    wr_data = wd;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (wr_hit && !rst) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   ra_i;
    logic [XLEN-1:0] rd_i;

    assign ra_i = ra[i*AW +: AW];

    always_comb begin
      rd_i = '0;
      if (ready && (ra_i != AW'(REG_ZERO))) begin
`ifdef REG_FILE_BYPASS_EN
        if (wr_hit && (ra_i == wa)) rd_i = wd;
        else                        rd_i = mem[ra_i];
`else
        rd_i = mem[ra_i];
`endif
      end
    end

    assign rd[i*XLEN +: XLEN] = rd_i;
  end

endmodule
